// File: rtl/relu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : relu_scheduler
// Purpose  : Round-robin scheduler that lets NUM_REQ requesters share a single
//            ReLU unit. A granted requester sees one start pulse to the ReLU
//            unit, then one completion pulse once the unit reports done.
//            Each transaction walks IDLE -> START -> WAIT -> DONE -> IDLE. All
//            outputs come from registers; none depend combinationally on an
//            input.
//
// Parameters:
//   NUM_REQ         number of requesters (2..16)
//   TIMEOUT_CYCLES  WAIT watchdog limit in cycles (used only when the
//                   RELU_SCHED_TIMEOUT_EN macro is defined)
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   i_req             per-requester request level
//   o_grant           one-hot grant, held from START through DONE
//   o_sel             binary index of the granted requester (ReLU data mux)
//   o_relu_start      one-cycle start pulse to the ReLU unit (START state)
//   i_relu_done_tick  one-cycle completion pulse from the ReLU unit
//   o_done            one-cycle completion pulse to the granted requester
//   o_busy            high in any state other than IDLE
//   o_timeout         one-cycle watchdog-abort flag, asserted with o_done
//
// Build option:
//   RELU_SCHED_TIMEOUT_EN  When defined, a watchdog forces WAIT -> DONE after
//                          TIMEOUT_CYCLES cycles with no done tick. When it is
//                          not defined, WAIT waits indefinitely and o_timeout
//                          is tied to 0.
//
// Revision : 1.0  initial release
// ============================================================================
module relu_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_sel,
  output logic                       o_relu_start,
  input  logic                       i_relu_done_tick,
  output logic [NUM_REQ-1:0]         o_done,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int SEL_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [SEL_W-1:0]     r_sel;
  logic [SEL_W-1:0]     r_last;      // last requester served in DONE
  logic                 r_start;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_busy;
  logic                 r_timeout;

  // --------------------------------------------------------------------------
  // Round-robin pick. The search starts one position after the last served
  // requester and wraps around, so the requester just served is checked last.
  // This is what stops one requester from starving the others.
  // --------------------------------------------------------------------------
  logic                 w_pick_valid;
  logic [SEL_W-1:0]     w_pick_sel;
  logic [SEL_W-1:0]     w_idx;
  logic [NUM_REQ-1:0]   w_pick_grant;

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_sel   = '0;
    w_idx        = '0;
    w_pick_grant = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = SEL_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_pick_valid && i_req[w_idx]) begin
        w_pick_valid = 1'b1;
        w_pick_sel   = w_idx;
      end
    end
    if (w_pick_valid) begin
      w_pick_grant[w_pick_sel] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // WAIT watchdog (optional)
  // --------------------------------------------------------------------------
`ifdef RELU_SCHED_TIMEOUT_EN
  localparam int               WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  c_WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            w_wdog_expire;

  // The counter holds 0 in the first WAIT cycle. It therefore reads
  // TIMEOUT_CYCLES-1 in the last permitted WAIT cycle, so DONE lands exactly
  // TIMEOUT_CYCLES cycles after WAIT entry.
  assign w_wdog_expire = (r_wdog == c_WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT && !w_wdog_expire) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  // The watchdog limit has no effect in this build.
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // --------------------------------------------------------------------------
  // Main FSM. Every output is a register that is set on the transition into
  // the state that owns it. This keeps the outputs Moore-style even though the
  // grant is chosen from the live request vector.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_last    <= SEL_W'(NUM_REQ - 1);
      r_start   <= 1'b0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      // Pulse outputs default low. Each one is raised for a single state only.
      r_start   <= 1'b0;
      r_done    <= '0;
      r_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_grant;
            r_sel   <= w_pick_sel;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end

        // A done tick is ignored here. The ReLU unit has not started yet.
        S_START: begin
          r_state <= S_WAIT;
        end

        // A done tick and watchdog expiry in the same cycle counts as a
        // normal completion.
        S_WAIT: begin
          if (i_relu_done_tick) begin
            r_done  <= r_grant;
            r_state <= S_DONE;
          end
`ifdef RELU_SCHED_TIMEOUT_EN
          else if (w_wdog_expire) begin
            r_done    <= r_grant;
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end
`endif
        end

        S_DONE: begin
          r_last  <= r_sel;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_sel        = r_sel;
  assign o_relu_start = r_start;
  assign o_done       = r_done;
  assign o_busy       = r_busy;
  assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_relu_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_scheduler
// Purpose  : Self-checking directed bench for relu_scheduler (NUM_REQ = 4).
//            Each vector has a hand-computed expected grant, index and pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_relu_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] i_req = '0;
  logic [3:0] o_grant;
  logic [1:0] o_sel;
  logic       o_relu_start;
  logic       i_relu_done_tick = 1'b0;
  logic [3:0] o_done;
  logic       o_busy;
  logic       o_timeout;

  int total = 0;
  int bad   = 0;
  int starts = 0;

  always #5 clk = ~clk;

  relu_scheduler #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req            (i_req),
    .o_grant          (o_grant),
    .o_sel            (o_sel),
    .o_relu_start     (o_relu_start),
    .i_relu_done_tick (i_relu_done_tick),
    .o_done           (o_done),
    .o_busy           (o_busy),
    .o_timeout        (o_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge. Start pulses are counted.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_relu_start === 1'b1) starts++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = '0;
    i_relu_done_tick = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    starts = 0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (o_relu_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check_val({tag, "_start_seen"}, {31'd0, o_relu_start}, 32'd1);
  endtask

  // Run one transaction. The done tick is sampled after lat WAIT-side cycles
  // (lat >= 1). If drop is set, i_req is removed right after the start pulse.
  task automatic do_txn(input string tag, input logic [3:0] exp_g, input int lat, input bit drop);
    int exp_sel;
    exp_sel = 0;
    for (int i = 0; i < 4; i++) if (exp_g[i]) exp_sel = i;
    starts = 0;
    wait_start(tag);
    check_val({tag, "_grant"}, {28'd0, o_grant}, {28'd0, exp_g});
    check_val({tag, "_sel"},   {30'd0, o_sel},   exp_sel);
    if (drop) i_req = '0;
    repeat (lat) step();
    check_val({tag, "_no_early_done"}, {28'd0, o_done}, 32'd0);
    i_relu_done_tick = 1'b1;
    step();
    i_relu_done_tick = 1'b0;
    check_val({tag, "_done"},       {28'd0, o_done},  {28'd0, exp_g});
    check_val({tag, "_grant_hold"}, {28'd0, o_grant}, {28'd0, exp_g});
    check_val({tag, "_timeout0"},   {31'd0, o_timeout}, 32'd0);
    step();
    check_val({tag, "_idle_done0"}, {28'd0, o_done},  32'd0);
    check_val({tag, "_idle_busy0"}, {31'd0, o_busy},  32'd0);
    check_val({tag, "_idle_grant0"}, {28'd0, o_grant}, 32'd0);
    check_val({tag, "_one_start"},  starts, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset state
    do_reset();
    check_val("rst_grant", {28'd0, o_grant}, 32'd0);
    check_val("rst_sel",   {30'd0, o_sel},   32'd0);
    check_val("rst_start", {31'd0, o_relu_start}, 32'd0);
    check_val("rst_done",  {28'd0, o_done},  32'd0);
    check_val("rst_busy",  {31'd0, o_busy},  32'd0);
    check_val("rst_tmo",   {31'd0, o_timeout}, 32'd0);

    // Single requester 1, done three cycles after start. The request is
    // dropped mid-transaction and the transaction must still complete.
    i_req = 4'b0010;
    do_txn("single1", 4'b0010, 3, 1'b1);

    // All requesters held high: round robin 0,1,2,3,0
    do_reset();
    i_req = 4'b1111;
    do_txn("rr0a", 4'b0001, 1, 1'b0);
    do_txn("rr1",  4'b0010, 2, 1'b0);
    do_txn("rr2",  4'b0100, 1, 1'b0);
    do_txn("rr3",  4'b1000, 4, 1'b0);
    do_txn("rr0b", 4'b0001, 1, 1'b0);

    // Requesters 1 and 3 held: alternation 1,3,1,3
    do_reset();
    i_req = 4'b1010;
    do_txn("alt1a", 4'b0010, 1, 1'b0);
    do_txn("alt3a", 4'b1000, 1, 1'b0);
    do_txn("alt1b", 4'b0010, 1, 1'b0);
    do_txn("alt3b", 4'b1000, 1, 1'b0);

    // A done tick in IDLE or in START must be ignored
    do_reset();
    i_relu_done_tick = 1'b1;
    step();
    i_relu_done_tick = 1'b0;
    check_val("ign_idle_busy", {31'd0, o_busy}, 32'd0);
    check_val("ign_idle_done", {28'd0, o_done}, 32'd0);
    i_req = 4'b0100;
    starts = 0;
    wait_start("ign");
    i_relu_done_tick = 1'b1;   // sampled while in START
    step();
    i_relu_done_tick = 1'b0;
    check_val("ign_start_done", {28'd0, o_done}, 32'd0);
    check_val("ign_start_busy", {31'd0, o_busy}, 32'd1);
    step();
    step();
    check_val("ign_wait_done", {28'd0, o_done}, 32'd0);
    check_val("ign_wait_busy", {31'd0, o_busy}, 32'd1);
    i_relu_done_tick = 1'b1;
    step();
    i_relu_done_tick = 1'b0;
    check_val("ign_final_done", {28'd0, o_done}, 32'h4);
    step();
    check_val("ign_final_busy", {31'd0, o_busy}, 32'd0);

    // Reset during WAIT for requester 2
    do_reset();
    i_req = 4'b0100;
    starts = 0;
    wait_start("midrst");
    step();
    step();
    check_val("midrst_in_wait", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_grant", {28'd0, o_grant}, 32'd0);
    check_val("midrst_sel",   {30'd0, o_sel},   32'd0);
    check_val("midrst_start", {31'd0, o_relu_start}, 32'd0);
    check_val("midrst_done",  {28'd0, o_done},  32'd0);
    check_val("midrst_busy",  {31'd0, o_busy},  32'd0);
    check_val("midrst_tmo",   {31'd0, o_timeout}, 32'd0);
    i_relu_done_tick = 1'b1;
    step();
    i_relu_done_tick = 1'b0;
    check_val("midrst_held_done", {28'd0, o_done}, 32'd0);
    i_req = 4'b1111;
    rst_n = 1'b1;
    do_txn("postrst", 4'b0001, 1, 1'b0);

    // Watchdog behaviour
    do_reset();
    i_req = 4'b0001;
    starts = 0;
    wait_start("wd");
    i_req = '0;
`ifdef RELU_SCHED_TIMEOUT_EN
    begin
      int at;
      at = 0;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (o_done !== 4'b0000 && at == 0) begin
          at = n;
          check_val("wd_done", {28'd0, o_done}, 32'd1);
          check_val("wd_tmo",  {31'd0, o_timeout}, 32'd1);
        end
      end
      // The start pulse is seen one cycle before WAIT entry, so the DONE
      // cycle falls 16 + 1 steps after the start observation.
      check_val("wd_latency", at, 32'd17);
      check_val("wd_idle_busy", {31'd0, o_busy}, 32'd0);
    end
`else
    begin
      int seen;
      seen = 0;
      repeat (110) begin
        step();
        if (o_done !== 4'b0000 || o_timeout !== 1'b0) seen++;
      end
      check_val("nowd_no_done", seen, 32'd0);
      check_val("nowd_busy",    {31'd0, o_busy}, 32'd1);
      check_val("nowd_grant",   {28'd0, o_grant}, 32'd1);
      i_relu_done_tick = 1'b1;
      step();
      i_relu_done_tick = 1'b0;
      check_val("nowd_done",  {28'd0, o_done}, 32'd1);
      check_val("nowd_tmo0",  {31'd0, o_timeout}, 32'd0);
      step();
      check_val("nowd_idle",  {31'd0, o_busy}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relu_scheduler.md
RELU_SCHEDULER -- requirements
Module: relu_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one ReLU unit (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: WAIT-state watchdog limit (used only with REQ-031).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester request level.
REQ-006 SHALL have port o_grant  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-007 SHALL have port o_sel  output  $clog2(NUM_REQ)  binary index of the granted requester, for the ReLU data mux.
REQ-008 SHALL have port o_relu_start  output  1  single-cycle start pulse to the ReLU unit.
REQ-009 SHALL have port i_relu_done_tick  input  1  single-cycle completion pulse from the ReLU unit.
REQ-010 SHALL have port o_done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port o_timeout  output  1  one-cycle watchdog-abort flag; constant 0 without REQ-031.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT, DONE; all outputs SHALL be registered or decoded from state (Moore); none SHALL depend combinationally on inputs.
REQ-014 In IDLE with i_req != 0, SHALL pick the first asserted requester searching round-robin from (last_served+1) mod NUM_REQ, register o_grant/o_sel, and enter START.
REQ-015 In IDLE with i_req == 0, SHALL remain in IDLE with o_grant = 0.
REQ-016 START SHALL last exactly one cycle with o_relu_start = 1, then enter WAIT.
REQ-017 WAIT SHALL hold until i_relu_done_tick = 1 is sampled, then enter DONE.
REQ-018 i_relu_done_tick SHALL be ignored in IDLE, START, and DONE.
REQ-019 DONE SHALL last one cycle with o_done[o_sel] = 1, update last_served to o_sel, then enter IDLE.
REQ-020 o_grant and o_sel SHALL be stable from START through DONE; o_grant SHALL be 0 in IDLE.
REQ-021 Deasserting i_req mid-transaction SHALL NOT abort the transaction; it SHALL complete through DONE.
REQ-022 Minimum transaction length SHALL be 4 cycles (IDLE, START, WAIT with done in its first cycle, DONE); back-to-back transactions SHALL have one IDLE cycle between DONE and the next START.
REQ-023 A requester served in DONE SHALL NOT be re-granted before every other requester asserting i_req in the intervening IDLE cycle is granted.
REQ-024 At most one o_relu_start pulse SHALL occur per grant; o_done SHALL be at most one-hot.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, o_grant = 0, o_sel = 0, o_relu_start = 0, o_done = 0, o_busy = 0, and o_timeout = 0.
REQ-026 Reset SHALL set last_served = NUM_REQ-1, so requester 0 has first priority.
REQ-027 Reset asserted in any state, including mid-WAIT, SHALL discard the transaction without issuing o_done.
REQ-028 The watchdog counter SHALL reset to 0.

Configuration
REQ-029 Macro RELU_SCHED_TIMEOUT_EN SHALL control the WAIT watchdog.
REQ-030 Without the macro, WAIT SHALL wait indefinitely and o_timeout SHALL be tied to 0.
REQ-031 With the macro, a counter SHALL clear on WAIT entry and increment each WAIT cycle; if it reaches TIMEOUT_CYCLES without a done tick, the FSM SHALL enter DONE with o_timeout = 1 for that DONE cycle alongside o_done. A done tick and the limit in the same cycle SHALL count as normal completion (o_timeout = 0).

Verification
REQ-032 i_req = 4'b0010 and done tick 3 cycles after start SHALL give o_grant = 4'b0010, o_sel = 1, one o_relu_start pulse, one o_done = 4'b0010 pulse, then IDLE.
REQ-033 i_req = 4'b1111 held constant SHALL give grant order 0,1,2,3,0 with exactly one start per grant.
REQ-034 i_req[1] re-asserted immediately with i_req[3] held SHALL give grant order 1,3,1,3.
REQ-035 A done tick pulsed in IDLE and in START SHALL produce no o_done and no state change beyond the normal START-to-WAIT transition.
REQ-036 rst_n pulsed low during WAIT for requester 2 SHALL zero all outputs immediately with no o_done; after release with i_req = 4'b1111, the first grant SHALL be requester 0.
REQ-037 With RELU_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no done tick SHALL give o_done plus o_timeout 16 cycles after WAIT entry; without the macro, the FSM SHALL stay in WAIT for 100+ cycles.
